// File: rtl/des_subkey_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : des_subkey_sequencer_pkg
//  Purpose  : Shared widths, state encoding, rotation schedule and the DES
//             PC1/PC2 permutations for the iterative key scheduler.
//  Revision : 1.0  initial release
// ============================================================================
package des_subkey_sequencer_pkg;

   localparam int KEY_W    = 64;
   localparam int CD_W     = 56;
   localparam int HALF_W   = 28;
   localparam int SUBKEY_W = 48;
   localparam int RND_W    = 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Left-rotation amount applied before producing subkey K(i+1)
   localparam logic [1:0] SHIFT [16] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
   };

   // Bit positions use DES numbering: bit 1 is the MSB of the source word
   localparam int PC1_TAB [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   // Drops the parity bits and splits the key into C (upper) and D (lower)
   function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
      logic [CD_W-1:0] r;
      r = '0;
      for (int i = 0; i < CD_W; i++) begin
         r[CD_W-1-i] = k[KEY_W-PC1_TAB[i]];
      end
      return r;
   endfunction

   // Compresses the 56-bit C/D state into a 48-bit round subkey
   function automatic logic [SUBKEY_W-1:0] pc2(input logic [CD_W-1:0] cd);
      logic [SUBKEY_W-1:0] r;
      r = '0;
      for (int i = 0; i < SUBKEY_W; i++) begin
         r[SUBKEY_W-1-i] = cd[CD_W-PC2_TAB[i]];
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/des_subkey_sequencer_cd_rotator.sv
`default_nettype none
// ============================================================================
//  Module   : des_subkey_sequencer_cd_rotator
//  Purpose  : Rotates the C and D halves of the key state independently by
//             one or two positions, left (encrypt) or right (decrypt).
//  Revision : 1.0  initial release
// ============================================================================
module des_subkey_sequencer_cd_rotator
   import des_subkey_sequencer_pkg::*;
(
   input  logic [CD_W-1:0] cd,
   input  logic [1:0]      amt,
   input  logic            dir,
   output logic [CD_W-1:0] cd_out
);

   logic [HALF_W-1:0] w_c;
   logic [HALF_W-1:0] w_d;
   logic [HALF_W-1:0] w_c_rot;
   logic [HALF_W-1:0] w_d_rot;
   logic              w_two;

   assign w_c   = cd[CD_W-1:HALF_W];
   assign w_d   = cd[HALF_W-1:0];
   // Only 1 and 2 occur in the schedule; anything other than 2 rotates by 1
   assign w_two = (amt == 2'd2);

   // Select one of four fixed rotations for each half
   always_comb begin
      w_c_rot = w_c;
      w_d_rot = w_d;
      case ({dir, w_two})
         2'b00: begin
            w_c_rot = {w_c[HALF_W-2:0], w_c[HALF_W-1]};
            w_d_rot = {w_d[HALF_W-2:0], w_d[HALF_W-1]};
         end
         2'b01: begin
            w_c_rot = {w_c[HALF_W-3:0], w_c[HALF_W-1:HALF_W-2]};
            w_d_rot = {w_d[HALF_W-3:0], w_d[HALF_W-1:HALF_W-2]};
         end
         2'b10: begin
            w_c_rot = {w_c[0], w_c[HALF_W-1:1]};
            w_d_rot = {w_d[0], w_d[HALF_W-1:1]};
         end
         default: begin
            w_c_rot = {w_c[1:0], w_c[HALF_W-1:2]};
            w_d_rot = {w_d[1:0], w_d[HALF_W-1:2]};
         end
      endcase
   end

   assign cd_out = {w_c_rot, w_d_rot};

endmodule
`default_nettype wire

// File: rtl/des_subkey_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : des_subkey_sequencer
//  Purpose  : Iterative DES key schedule. One C/D register and one rotator
//             issue a 48-bit subkey per valid/ready handshake, in K1..K16
//             order for encryption or K16..K1 order for decryption.
//  Revision : 1.0  initial release
// ============================================================================
module des_subkey_sequencer
   import des_subkey_sequencer_pkg::*;
#(
   parameter int ROUNDS = 16
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                decrypt,
   input  logic [KEY_W-1:0]    key,
   input  logic                abort,
   output logic                ready,
   output logic                subkey_valid,
   input  logic                subkey_ready,
   output logic [SUBKEY_W-1:0] subkey,
   output logic [RND_W-1:0]    subkey_idx,
   output logic                done
);

   localparam logic [RND_W-1:0] c_LAST_RND = RND_W'(ROUNDS - 1);

   state_t            r_state;
   logic [CD_W-1:0]   r_cd;
   logic [RND_W-1:0]  r_rnd;
   logic              r_mode;
   logic              r_done;

   logic [CD_W-1:0]   w_pc1_cd;
   logic [CD_W-1:0]   w_start_cd;
   logic [CD_W-1:0]   w_step_cd;
   logic [1:0]        w_step_amt;

   assign w_pc1_cd = pc1(key);

   // Encrypt jobs preload C1D1 so K1 is ready on the first RUN cycle
   assign w_start_cd = {w_pc1_cd[CD_W-2:HALF_W], w_pc1_cd[CD_W-1],
                        w_pc1_cd[HALF_W-2:0],    w_pc1_cd[HALF_W-1]};

   // Encrypt looks ahead to the next round's shift; decrypt undoes the
   // shift that produced the subkey just issued (total rotation is 28, so
   // C0D0 already equals C16D16)
   always_comb begin
      w_step_amt = SHIFT[r_rnd + 4'd1];
      if (r_mode) begin
         w_step_amt = SHIFT[c_LAST_RND - r_rnd];
      end
   end

   des_subkey_sequencer_cd_rotator u_step_rot (
      .cd     (r_cd),
      .amt    (w_step_amt),
      .dir    (r_mode),
      .cd_out (w_step_cd)
   );

   // Job control: accept start in IDLE, advance on handshake, abort wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cd    <= '0;
         r_rnd   <= '0;
         r_mode  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start && !abort) begin
                  r_mode  <= decrypt;
                  r_rnd   <= '0;
                  r_cd    <= decrypt ? w_pc1_cd : w_start_cd;
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (abort) begin
                  r_state <= IDLE;
               end else if (subkey_ready) begin
                  if (r_rnd == c_LAST_RND) begin
                     r_state <= IDLE;
                     r_done  <= 1'b1;
                  end else begin
                     r_rnd <= r_rnd + 4'd1;
                     r_cd  <= w_step_cd;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign ready        = (r_state == IDLE);
   assign subkey_valid = (r_state == RUN);
   assign subkey       = pc2(r_cd);
   assign subkey_idx   = r_mode ? (c_LAST_RND - r_rnd) : r_rnd;
   assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_des_subkey_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_des_subkey_sequencer
//  Purpose  : Self-checking bench for des_subkey_sequencer. An independent
//             key-schedule model fills a scoreboard when a job is accepted;
//             entries are compared while valid and popped on handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_des_subkey_sequencer;

   localparam logic [63:0] c_KEY_REF = 64'h1334_5779_9BBC_DFF1;
   localparam logic [63:0] c_KEY_B   = 64'h0E32_9232_EA6D_0D73;
   localparam logic [47:0] c_K1      = 48'h1B02_EFFC_7072;
   localparam logic [47:0] c_K2      = 48'h79AE_D9DB_C9E5;
   localparam logic [47:0] c_K16     = 48'hCB3D_8B0E_17F5;

   localparam int M_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
   localparam int M_PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };
   localparam int M_PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   typedef struct packed {
      logic [47:0] sk;
      logic [3:0]  idx;
      logic        last;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        decrypt;
   logic [63:0] key;
   logic        abort;
   logic        ready;
   logic        subkey_valid;
   logic        subkey_ready;
   logic [47:0] subkey;
   logic [3:0]  subkey_idx;
   logic        done;

   exp_t sb[$];
   logic busy;
   int   n_checks;
   int   n_fail;
   int   cyc;
   int   t0;

   des_subkey_sequencer #(.ROUNDS(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .decrypt      (decrypt),
      .key          (key),
      .abort        (abort),
      .ready        (ready),
      .subkey_valid (subkey_valid),
      .subkey_ready (subkey_ready),
      .subkey       (subkey),
      .subkey_idx   (subkey_idx),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [55:0] model_pc1(input logic [63:0] k);
      logic [55:0] r;
      r = '0;
      for (int i = 0; i < 56; i++) r[55-i] = k[64-M_PC1[i]];
      return r;
   endfunction

   function automatic logic [47:0] model_pc2(input logic [55:0] cd);
      logic [47:0] r;
      r = '0;
      for (int i = 0; i < 48; i++) r[47-i] = cd[56-M_PC2[i]];
      return r;
   endfunction

   // Textbook schedule: cumulative left shifts from C0D0, then ordering
   task automatic push_job(input logic [63:0] k, input logic dec);
      logic [55:0] cd;
      logic [27:0] c;
      logic [27:0] d;
      logic [47:0] ks [16];
      exp_t        e;
      cd = model_pc1(k);
      c  = cd[55:28];
      d  = cd[27:0];
      for (int i = 0; i < 16; i++) begin
         for (int s = 0; s < M_SHIFT[i]; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
         ks[i] = model_pc2({c, d});
      end
      for (int i = 0; i < 16; i++) begin
         e.idx  = dec ? 4'(15 - i) : 4'(i);
         e.sk   = ks[e.idx];
         e.last = (i == 15);
         sb.push_back(e);
      end
   endtask

   // One clock: compare outputs against the scoreboard for the inputs now
   // being driven, advance the model, then check control outputs after edge
   task automatic step();
      exp_t e;
      logic exp_done_n;
      logic busy_n;
      exp_done_n = 1'b0;
      busy_n     = busy;
      if (busy) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 64'(sb.size()), 64'd16);
         end else begin
            e = sb[0];
            check("subkey", 64'(subkey), 64'(e.sk));
            check("subkey_idx", 64'(subkey_idx), 64'(e.idx));
            if (abort) begin
               sb.delete();
               busy_n = 1'b0;
            end else if (subkey_ready) begin
               void'(sb.pop_front());
               if (e.last) begin
                  exp_done_n = 1'b1;
                  busy_n     = 1'b0;
               end
            end
         end
      end else if (start && !abort) begin
         push_job(key, decrypt);
         busy_n = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
      busy = busy_n;
      check("subkey_valid", 64'(subkey_valid), 64'(busy));
      check("ready", 64'(ready), 64'(!busy));
      check("done", 64'(done), 64'(exp_done_n));
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 60) begin
         step();
         n++;
      end
      check("done_seen", 64'(done), 64'd1);
   endtask

   task automatic run_ref_job(input string tag);
      key          = c_KEY_REF;
      decrypt      = 1'b0;
      subkey_ready = 1'b1;
      start        = 1'b1;
      step();
      start = 1'b0;
      check({tag, "_k1"}, 64'(subkey), 64'(c_K1));
      check({tag, "_idx0"}, 64'(subkey_idx), 64'd0);
      step();
      check({tag, "_k2"}, 64'(subkey), 64'(c_K2));
      check({tag, "_idx1"}, 64'(subkey_idx), 64'd1);
      repeat (14) step();
      check({tag, "_k16"}, 64'(subkey), 64'(c_K16));
      check({tag, "_idx15"}, 64'(subkey_idx), 64'd15);
      check({tag, "_no_early_done"}, 64'(done), 64'd0);
      step();
      check({tag, "_done"}, 64'(done), 64'd1);
      step();
      check({tag, "_done_once"}, 64'(done), 64'd0);
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      cyc          = 0;
      busy         = 1'b0;
      rst_n        = 1'b0;
      start        = 1'b0;
      decrypt      = 1'b0;
      key          = '0;
      abort        = 1'b0;
      subkey_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 64'(ready), 64'd1);
      check("rst_valid", 64'(subkey_valid), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_idx", 64'(subkey_idx), 64'd0);
      check("rst_subkey", 64'(subkey), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // 1: encrypt reference key
      run_ref_job("t1");

      // 2: decrypt reference key, reversed order
      key     = c_KEY_REF;
      decrypt = 1'b1;
      start   = 1'b1;
      step();
      start = 1'b0;
      check("t2_first", 64'(subkey), 64'(c_K16));
      check("t2_first_idx", 64'(subkey_idx), 64'd15);
      repeat (15) step();
      check("t2_last", 64'(subkey), 64'(c_K1));
      check("t2_last_idx", 64'(subkey_idx), 64'd0);
      step();
      check("t2_done", 64'(done), 64'd1);
      step();

      // 3: backpressure for three cycles at rnd=5
      key     = c_KEY_REF;
      decrypt = 1'b0;
      start   = 1'b1;
      step();
      start = 1'b0;
      t0    = cyc;
      repeat (5) step();
      subkey_ready = 1'b0;
      repeat (3) step();
      subkey_ready = 1'b1;
      wait_done();
      check("t3_done_latency", 64'(cyc - t0), 64'd19);
      step();

      // 4: start pulses during RUN ignored, start in done cycle accepted
      key     = c_KEY_REF;
      decrypt = 1'b0;
      start   = 1'b1;
      step();
      for (int i = 0; i < 16; i++) begin
         start   = (i == 3 || i == 8);
         key     = c_KEY_B;
         decrypt = (i == 3 || i == 8);
         step();
      end
      start = 1'b0;
      check("t4_done", 64'(done), 64'd1);
      key     = c_KEY_B;
      decrypt = 1'b1;
      start   = 1'b1;
      step();
      start = 1'b0;
      check("t4_second_valid", 64'(subkey_valid), 64'd1);
      wait_done();
      step();

      // 5: abort at rnd=7 together with a handshake
      key     = c_KEY_REF;
      decrypt = 1'b0;
      start   = 1'b1;
      step();
      start = 1'b0;
      repeat (7) step();
      check("t5_idx_before_abort", 64'(subkey_idx), 64'd7);
      abort = 1'b1;
      step();
      check("t5_abort_valid", 64'(subkey_valid), 64'd0);
      check("t5_abort_ready", 64'(ready), 64'd1);
      start = 1'b1;
      step();
      check("t5_start_with_abort", 64'(subkey_valid), 64'd0);
      start = 1'b0;
      abort = 1'b0;
      step();
      run_ref_job("t5");

      // 6: asynchronous reset at rnd=10
      key     = c_KEY_REF;
      decrypt = 1'b0;
      start   = 1'b1;
      step();
      start = 1'b0;
      repeat (10) step();
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 64'(subkey_valid), 64'd0);
      check("t6_rst_ready", 64'(ready), 64'd1);
      check("t6_rst_done", 64'(done), 64'd0);
      sb.delete();
      busy = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step();
      run_ref_job("t6");

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global bound in case a wait above stops advancing
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got %0d cycles expected fewer", cyc);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
